// File: rtl/multi_digit_score_draw.sv
// BCD score counter with a digit-serial adder and a two-stage glyph renderer.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros in the rendered score.
module multi_digit_score_draw #(
  parameter int         NUM_DIGITS  = 4,
  parameter int         DIGIT_W     = 16,
  parameter int         DIGIT_H     = 32,
  parameter int         SCALE_LOG2  = 0,
  parameter logic [7:0] DIGIT_COLOR = 8'hFF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [10:0]             pixelX,
  input  logic [10:0]             pixelY,
  input  logic [10:0]             topLeftX,
  input  logic [10:0]             topLeftY,
  input  logic                    addValid,
  input  logic [3:0]              addValue,
  output logic                    addReady,
  input  logic                    clearScore,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout,
  output logic [4*NUM_DIGITS-1:0] scoreBcd,
  output logic                    overflow
);

  localparam int          DW_LOG2    = $clog2(DIGIT_W);
  localparam int          ROW_W      = $clog2(DIGIT_H);
  localparam int          ROM_DEPTH  = 10 * DIGIT_H;
  localparam int          ROM_AW     = $clog2(ROM_DEPTH);
  localparam int          SW         = 4 * NUM_DIGITS;
  localparam logic [10:0] SPAN_X     = 11'(NUM_DIGITS * DIGIT_W * (1 << SCALE_LOG2));
  localparam logic [10:0] SPAN_Y     = 11'(DIGIT_H * (1 << SCALE_LOG2));
  localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam int          TH         = (DIGIT_H >= 8) ? DIGIT_H / 8 : 1;
  localparam int          TW         = (DIGIT_W >= 8) ? DIGIT_W / 8 : 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   work_q, work_d, score_q, score_d, shadow_q, shadow_d;
  logic            ovf_q, ovf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      carry_q, carry_d;
  logic [3:0]      cur_digit, new_digit;
  logic [4:0]      sum_w;
  logic            carry_out;

  assign addReady = (state_q == IDLE) && !clearScore;
  assign scoreBcd = score_q;
  assign overflow = ovf_q;
  assign RGBout   = DIGIT_COLOR;

  // One decimal digit of the working register per cycle; carry_q holds the addend for digit 0.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (3'(i) == cnt_q) cur_digit = work_q[4*i +: 4];
    sum_w = {1'b0, cur_digit} + {1'b0, carry_q};
    if (sum_w >= 5'd10) begin
      new_digit = 4'(sum_w - 5'd10);
      carry_out = 1'b1;
    end else begin
      new_digit = sum_w[3:0];
      carry_out = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    score_d  = score_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    shadow_d = startOfFrame ? score_q : shadow_q;
    case (state_q)
      IDLE: if (addValid && addReady) begin
        carry_d = (addValue > 4'd9) ? 4'd0 : addValue;
        cnt_d   = 3'd0;
        state_d = ADD;
      end
      ADD: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (3'(i) == cnt_q) work_d[4*i +: 4] = new_digit;
        carry_d = {3'b000, carry_out};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == LAST_DIGIT) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (carry_out) begin
            work_d  = {NUM_DIGITS{4'h9}};
            score_d = {NUM_DIGITS{4'h9}};
            ovf_d   = 1'b1;
          end else begin
            score_d = work_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clearScore) begin
      state_d = IDLE;
      work_d  = '0;
      score_d = '0;
      ovf_d   = 1'b0;
      cnt_d   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      work_q   <= '0;
      score_q  <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= 3'd0;
      carry_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      score_q  <= score_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
    end
  end

  // Seven-segment style glyphs: bar thickness is 1/8 of the glyph size.
  function automatic logic [DIGIT_W-1:0] glyph_row(input int g, input int r);
    logic [6:0]         seg;
    logic [DIGIT_W-1:0] bits;
    logic               upper;
    case (g)
      0: seg = 7'b1111110;  1: seg = 7'b0110000;  2: seg = 7'b1101101;
      3: seg = 7'b1111001;  4: seg = 7'b0110011;  5: seg = 7'b1011011;
      6: seg = 7'b1011111;  7: seg = 7'b1110000;  8: seg = 7'b1111111;
      9: seg = 7'b1111011;  default: seg = 7'b0000000;
    endcase
    upper = r < DIGIT_H / 2;
    for (int c = 0; c < DIGIT_W; c++)
      bits[DIGIT_W-1-c] = (seg[6] && r < TH) ||
                          (seg[5] && c >= DIGIT_W - TW && upper) ||
                          (seg[4] && c >= DIGIT_W - TW && !upper) ||
                          (seg[3] && r >= DIGIT_H - TH) ||
                          (seg[2] && c < TW && !upper) ||
                          (seg[1] && c < TW && upper) ||
                          (seg[0] && r >= DIGIT_H/2 - TH/2 && r < DIGIT_H/2 - TH/2 + TH);
    return bits;
  endfunction

  logic [DIGIT_W-1:0] glyph_rom [ROM_DEPTH];
  for (genvar gi = 0; gi < 10; gi++) begin : g_glyph
    for (genvar ri = 0; ri < DIGIT_H; ri++) begin : g_row
      assign glyph_rom[gi*DIGIT_H + ri] = glyph_row(gi, ri);
    end
  end

  logic [11:0]        offx_w, offy_w;
  logic [10:0]        scx, scy;
  logic [2:0]         screen_pos, digit_idx;
  logic [31:0]        shadow_ext;
  logic [7:0]         blank_mask;
  logic               inside_c;

  assign offx_w     = {1'b0, pixelX} - {1'b0, topLeftX};
  assign offy_w     = {1'b0, pixelY} - {1'b0, topLeftY};
  assign inside_c   = !offx_w[11] && (offx_w[10:0] < SPAN_X) && !offy_w[11] && (offy_w[10:0] < SPAN_Y);
  assign scx        = offx_w[10:0] >> SCALE_LOG2;
  assign scy        = offy_w[10:0] >> SCALE_LOG2;
  assign screen_pos = 3'(scx >> DW_LOG2);
  assign digit_idx  = LAST_DIGIT - screen_pos;
  assign shadow_ext = 32'(shadow_q);

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;
  always_comb begin
    blank_mask = '0;
    seen_nz    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (shadow_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank_mask[i] = !seen_nz;
    end
  end
`else
  assign blank_mask = '0;
`endif

  logic               s1_inside_q, s1_blank_q, draw_q;
  logic [3:0]         s1_digit_q;
  logic [ROW_W-1:0]   s1_row_q;
  logic [DW_LOG2-1:0] s1_col_q;
  logic [ROM_AW-1:0]  rom_addr;
  logic [DIGIT_W-1:0] rom_word;

  assign rom_addr       = ROM_AW'(int'(s1_digit_q) * DIGIT_H + int'(s1_row_q));
  assign rom_word       = glyph_rom[rom_addr];
  assign drawingRequest = draw_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_inside_q <= 1'b0;
      s1_blank_q  <= 1'b0;
      s1_digit_q  <= 4'd0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      draw_q      <= 1'b0;
    end else begin
      s1_inside_q <= inside_c;
      s1_blank_q  <= blank_mask[digit_idx];
      s1_digit_q  <= shadow_ext[{digit_idx, 2'b00} +: 4];
      s1_row_q    <= ROW_W'(scy);
      s1_col_q    <= DW_LOG2'(scx);
      draw_q      <= rom_word[~s1_col_q] & s1_inside_q & ~s1_blank_q;
    end
  end

endmodule

// File: tb/tb_multi_digit_score_draw.sv
// Scoreboard bench: adds and pixels are predicted from decimal arithmetic and
// seven-segment geometry, then checked by an independent negedge monitor.
module tb_multi_digit_score_draw;
  localparam int N = 4;

  logic        clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0;
  logic        addValid = 1'b0, clearScore = 1'b0;
  logic [3:0]  addValue = 4'd0;
  logic [10:0] pixelX = 11'd0, pixelY = 11'd0, topLeftX = 11'd100, topLeftY = 11'd50;
  logic        addReady, drawingRequest, overflow;
  logic [7:0]  RGBout;
  logic [15:0] scoreBcd;

  multi_digit_score_draw dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .addValid(addValid), .addValue(addValue), .addReady(addReady),
    .clearScore(clearScore), .drawingRequest(drawingRequest), .RGBout(RGBout),
    .scoreBcd(scoreBcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] bcd; logic ovf; } exp_t;
  exp_t add_q[$];
  bit   pix_q[$];
  int   checks = 0, errors = 0;
  int   model_score = 0, model_shadow = 0;
  bit   model_ovf = 1'b0, pix_vld = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pow10(int e);
    int p = 1;
    for (int i = 0; i < e; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit glyph(int d, int r, int c);
    bit [6:0] m;
    case (d)
      0: m = 7'h7E; 1: m = 7'h30; 2: m = 7'h6D; 3: m = 7'h79; 4: m = 7'h33;
      5: m = 7'h5B; 6: m = 7'h5F; 7: m = 7'h70; 8: m = 7'h7F; 9: m = 7'h7B;
      default: m = 7'h00;
    endcase
    return (m[6] && r < 4) || (m[5] && c >= 14 && r < 16) || (m[4] && c >= 14 && r >= 16) ||
           (m[3] && r >= 28) || (m[2] && c < 2 && r >= 16) || (m[1] && c < 2 && r < 16) ||
           (m[0] && r >= 14 && r < 18);
  endfunction

  function automatic bit expect_pix(int px, int py);
    int ox, oy, idx, val;
    ox = px - int'(topLeftX);
    oy = py - int'(topLeftY);
    if (ox < 0 || ox >= N * 16 || oy < 0 || oy >= 32) return 1'b0;
    idx = N - 1 - ox / 16;
    val = (model_shadow / pow10(idx)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && model_shadow < pow10(idx)) return 1'b0;
`endif
    return glyph(val, oy, ox % 16);
  endfunction

  // Monitor: add completions, score atomicity and the pixel stream.
  int          cyc = 0, hs_cyc = 0;
  bit          pending = 1'b0, prev_block = 1'b1, done_now, pv_d1 = 1'b0, pv_d2 = 1'b0, pix_exp;
  logic [15:0] last_score = 16'h0;
  exp_t        e_mon;

  always @(negedge clk) begin
    cyc++;
    done_now = 1'b0;
    if (!resetN || clearScore) pending = 1'b0;
    else if (pending && addReady) begin
      done_now = 1'b1;
      pending  = 1'b0;
      if (add_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL add_unexpected: got completion with score %h, required no completion", scoreBcd);
      end else begin
        e_mon = add_q.pop_front();
        chk("add_score", 32'(scoreBcd), 32'(e_mon.bcd));
        chk("add_overflow", 32'(overflow), 32'(e_mon.ovf));
        chk("add_latency", cyc - hs_cyc, N + 1);
        $display("ADD done score=%h overflow=%0d latency=%0d", scoreBcd, overflow, cyc - hs_cyc);
      end
    end
    if (resetN && addValid && addReady) begin
      pending = 1'b1;
      hs_cyc  = cyc;
    end
    if (scoreBcd !== last_score) begin
      checks++;
      if (!(done_now || prev_block || !resetN)) begin
        errors++;
        $display("FAIL score_atomic: got %h outside a commit, required %h", scoreBcd, last_score);
      end
      last_score = scoreBcd;
    end
    prev_block = !resetN || clearScore;
    if (pv_d2) begin
      if (pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL draw_queue: got empty queue, required an expected pixel");
      end else begin
        pix_exp = pix_q.pop_front();
        chk("drawingRequest", 32'(drawingRequest), 32'(pix_exp));
      end
    end
    pv_d2 = pv_d1;
    pv_d1 = pix_vld;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!addReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!addReady) chk("ready_timeout", 32'(addReady), 32'd1);
    step();
  endtask

  task automatic do_add(int val, bit abort);
    exp_t e;
    addValid = 1'b1;
    addValue = 4'(val);
    @(negedge clk);
    if (!abort) begin
      if (val <= 9) begin
        model_score += val;
        if (model_score > 9999) begin
          model_score = 9999;
          model_ovf   = 1'b1;
        end
      end
      e.bcd = to_bcd(model_score);
      e.ovf = model_ovf;
      add_q.push_back(e);
    end
    step();
    addValid = 1'b0;
    if (abort) begin
      repeat (2) step();
      clearScore = 1'b1;
      step();
      clearScore  = 1'b0;
      model_score = 0;
      model_ovf   = 1'b0;
    end
    wait_ready();
  endtask

  task automatic add_to(int target);
    while (model_score < target) do_add((target - model_score > 9) ? 9 : target - model_score, 1'b0);
  endtask

  task automatic clear_score();
    clearScore = 1'b1;
    step();
    clearScore  = 1'b0;
    model_score = 0;
    model_ovf   = 1'b0;
    @(negedge clk);
    chk("clear_score", 32'(scoreBcd), 32'h0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    step();
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    model_shadow = model_score;
  endtask

  task automatic drive_pix(int x, int y);
    pixelX  = 11'(x);
    pixelY  = 11'(y);
    pix_vld = 1'b1;
    pix_q.push_back(expect_pix(x, y));
    step();
  endtask

  task automatic scan(int n);
    int lo;
    lo = (int'(topLeftX) >= 10) ? int'(topLeftX) - 10 : 0;
    for (int i = 0; i < n; i++)
      drive_pix($urandom_range(lo, int'(topLeftX) + N * 16 + 10),
                $urandom_range((int'(topLeftY) >= 6) ? int'(topLeftY) - 6 : 0, int'(topLeftY) + 38));
    pix_vld = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_score", 32'(scoreBcd), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_draw", 32'(drawingRequest), 32'd0);
    chk("reset_ready", 32'(addReady), 32'd1);
    resetN = 1'b1;
    step();
    chk("rgb_constant", 32'(RGBout), 32'hFF);

    do_add(7, 1'b0);
    do_add(5, 1'b0);
    chk("score_0012", 32'(scoreBcd), 32'h0012);

    add_to(999);
    do_add(1, 1'b0);
    chk("carry_1000", 32'(scoreBcd), 32'h1000);

    add_to(9995);
    do_add(9, 1'b0);
    chk("saturate_9999", 32'(scoreBcd), 32'h9999);
    chk("saturate_ovf", 32'(overflow), 32'd1);
    do_add(3, 1'b0);
    chk("saturate_hold", 32'(scoreBcd), 32'h9999);
    clear_score();

    repeat (25) do_add($urandom_range(0, 15), 1'b0);

    // clearScore and addValid together: add refused and dropped
    clearScore = 1'b1;
    addValid   = 1'b1;
    addValue   = 4'd5;
    @(negedge clk);
    chk("prio_ready", 32'(addReady), 32'd0);
    step();
    clearScore  = 1'b0;
    addValid    = 1'b0;
    model_score = 0;
    model_ovf   = 1'b0;
    repeat (N + 2) step();
    chk("prio_score", 32'(scoreBcd), 32'h0);

    add_to(300);
    do_add(4, 1'b1);
    chk("abort_score", 32'(scoreBcd), 32'h0);
    chk("abort_ready", 32'(addReady), 32'd1);

    // reset in the middle of an add
    add_to(123);
    addValid = 1'b1;
    addValue = 4'd6;
    step();
    addValid = 1'b0;
    step();
    resetN = 1'b0;
    #2;
    chk("async_reset_score", 32'(scoreBcd), 32'h0);
    @(posedge clk);
    #1;
    resetN       = 1'b1;
    model_score  = 0;
    model_ovf    = 1'b0;
    model_shadow = 0;
    @(negedge clk);
    chk("post_reset_ready", 32'(addReady), 32'd1);
    chk("post_reset_score", 32'(scoreBcd), 32'h0);
    step();

    // rendering at origin (100,50) with shadow 0042
    add_to(42);
    sof();
    drive_pix(152, 50);
    drive_pix(100, 50);
    drive_pix(116, 50);
    drive_pix(99, 50);
    scan(300);
    do_add(1, 1'b0);
    scan(150);
    sof();
    scan(150);
    clear_score();
    sof();
    scan(100);
    add_to(1000);
    sof();
    scan(100);
    topLeftX = 11'd5;
    topLeftY = 11'd3;
    scan(150);

    repeat (4) step();
    chk("add_queue_drained", add_q.size(), 0);
    chk("pix_queue_drained", pix_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_digit_score_draw.md
MULTI_DIGIT_SCORE_DRAW -- requirements
Module: multi_digit_score_draw

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of decimal digits displayed (1..8).
REQ-002 SHALL have parameter DIGIT_W, default 16, glyph width in pixels (power of two).
REQ-003 SHALL have parameter DIGIT_H, default 32, glyph height in pixels.
REQ-004 SHALL have parameter SCALE_LOG2, default 0, integer pixel magnification as log2 (0 or 1).
REQ-005 SHALL have parameter DIGIT_COLOR, default 8'hFF, fixed RGB332 output colour.
REQ-006 SHALL have port clk  in  1  pixel clock.
REQ-007 SHALL have port resetN  in  1  asynchronous active-low reset.
REQ-008 SHALL have port startOfFrame  in  1  one-cycle pulse at frame start.
REQ-009 SHALL have ports pixelX, pixelY  in  11 each  current pixel position.
REQ-010 SHALL have ports topLeftX, topLeftY  in  11 each  display origin.
REQ-011 SHALL have ports addValid in 1, addValue in 4, addReady out 1  score-increment handshake.
REQ-012 SHALL have port clearScore  in  1  synchronous score clear.
REQ-013 SHALL have ports drawingRequest out 1, RGBout out 8  pixel output.
REQ-014 SHALL have ports scoreBcd out 4*NUM_DIGITS (committed score, digit 0 = LS nibble) and overflow out 1 (sticky).

Function
REQ-015 SHALL hold a 10-glyph (0-9) DIGIT_W x DIGIT_H bitmap ROM; bit MSB = leftmost pixel.
REQ-016 SHALL use the add FSM states IDLE, ADD; addReady=1 only in IDLE with clearScore=0.
REQ-017 SHALL, on addValid&addReady, capture addValue and enter ADD; values 10-15 acknowledged but add 0.
REQ-018 SHALL in ADD process one BCD digit per cycle, LS first, with decimal carry; return to IDLE after NUM_DIGITS cycles.
REQ-019 SHALL commit the working register to scoreBcd on the IDLE-return cycle; scoreBcd never shows partial sums.
REQ-020 SHALL, on carry out of the MS digit, commit all digits = 9 and set overflow; further adds keep all 9s.
REQ-021 SHALL give clearScore priority over everything: zero working, committed and overflow next cycle, abort ADD, go IDLE.
REQ-022 SHALL copy scoreBcd into a display shadow register only on startOfFrame; rendering uses the shadow only.
REQ-023 SHALL compute offX=pixelX-topLeftX, offY=pixelY-topLeftY; inside when 0<=offX<NUM_DIGITS*DIGIT_W<<SCALE_LOG2 and 0<=offY<DIGIT_H<<SCALE_LOG2.
REQ-024 SHALL select screen digit offX>>(log2(DIGIT_W)+SCALE_LOG2), leftmost = most significant; glyph row/col = offY, offX low bits, each >>SCALE_LOG2.
REQ-025 SHALL have 2-cycle latency: stage 1 registers inside/digit/row/col, stage 2 registers drawingRequest = ROM bit & inside.
REQ-026 SHALL drive RGBout = DIGIT_COLOR constantly.

Reset
REQ-027 SHALL on resetN=0 asynchronously clear: FSM to IDLE, working/committed/shadow to 0, overflow 0, pipeline registers and drawingRequest 0.
REQ-028 SHALL, on reset mid-ADD, discard the partial sum; addReady=1 the first cycle after release.

Configuration
REQ-029 SHALL, with LEADING_ZERO_BLANK_EN defined, force drawingRequest=0 for shadow digits that are zero and more significant than the most significant non-zero digit; digit 0 always drawn.
REQ-030 SHALL, without LEADING_ZERO_BLANK_EN, draw all NUM_DIGITS digits including leading zeros.

Verification
REQ-031 SHALL test add: score 0, addValue=7 then 5 -> scoreBcd 16'h0012, each add takes NUM_DIGITS+1 cycles addValid-to-addReady.
REQ-032 SHALL test carry chain: score 0999 + 1 -> 16'h1000 committed atomically, no intermediate value seen on scoreBcd.
REQ-033 SHALL test saturation: score 9995 + 9 -> 16'h9999, overflow=1; clearScore -> 16'h0000, overflow=0.
REQ-034 SHALL test priority: clearScore and addValid same cycle -> addReady=0, score 0, add dropped; clearScore mid-ADD aborts.
REQ-035 SHALL test rendering: origin (100,50), shadow 0042, pixel in digit 3 row 0 with ROM bit 1 -> drawingRequest=1 two cycles later; score change mid-frame not visible until next startOfFrame.
REQ-036 SHALL test blanking: shadow 0042 with LEADING_ZERO_BLANK_EN -> digits 0-1 (screen left) never drawn; without it -> both zeros drawn.
